// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer, instruction memory, program counter and datapath.
// The sequencer side is the master; memory/PC/datapath together form the slave side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic              imem_ack;
  logic [7:0]        imem_rdata;
  logic [ADDR_W-1:0] pc_cur;
  logic              pc_en;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [7:0]        ir;
  logic              exec_valid;
  logic              exec_done;
  logic              zero_flag;

  modport master (
    output imem_req, pc_en, pc_load, pc_in, ir, exec_valid,
    input  imem_ack, imem_rdata, pc_cur, exec_done, zero_flag
  );

  modport slave (
    input  imem_req, pc_en, pc_load, pc_in, ir, exec_valid,
    output imem_ack, imem_rdata, pc_cur, exec_done, zero_flag
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Front-end control FSM of the 8-bit CPU: fetches instruction bytes, resolves JMP/JZ
// locally and hands every other opcode to the datapath with an exec_valid/exec_done handshake.
module fetch_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                WAIT_MAX  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  fetch_sequencer_if.master      bus,
  output logic                   halted,
  output logic                   fault
);

  localparam int              CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_FETCH_OP,
    ST_JUMP,
    ST_HALT,
    ST_FAULT
  } state_t;

  function automatic logic op_is_jmp(input logic [7:0] instr);
    return instr[7:4] == 4'hA;
  endfunction

  function automatic logic op_is_jz(input logic [7:0] instr);
    return instr[7:4] == 4'hB;
  endfunction

  function automatic logic op_is_hlt(input logic [7:0] instr);
    return instr[7:4] == 4'hF;
  endfunction

  state_t            state, state_nxt;
  logic [7:0]        ir_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              exec_vld_q;

  logic              req_cyc;
  logic              accept;
  logic              timeout;
  logic              jump_taken;

  always_comb begin
    req_cyc    = (state == ST_FETCH) || (state == ST_FETCH_OP);
    accept     = req_cyc && bus.imem_ack;
    // Counter holds the number of already-elapsed unacked cycles, so cycle WAIT_MAX sees WAIT_MAX-1.
    timeout    = req_cyc && !bus.imem_ack && (wait_cnt == CNT_LAST);
    jump_taken = op_is_jmp(ir_q) || (op_is_jz(ir_q) && bus.zero_flag);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (run) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (accept)       state_nxt = ST_DECODE;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_DECODE: begin
        if (op_is_hlt(ir_q))                       state_nxt = ST_HALT;
        else if (op_is_jmp(ir_q) || op_is_jz(ir_q)) state_nxt = ST_FETCH_OP;
        else                                       state_nxt = ST_EXEC;
      end
      ST_EXEC:     if (bus.exec_done) state_nxt = ST_FETCH;
      ST_FETCH_OP: begin
        if (accept)       state_nxt = ST_JUMP;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_JUMP:     state_nxt = ST_FETCH;
      ST_HALT:     if (run) state_nxt = ST_FETCH;
      ST_FAULT:    state_nxt = ST_FAULT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from state so an asynchronous reset drops them in the same cycle.
  always_comb begin
    bus.imem_req   = req_cyc;
    bus.pc_en      = accept;
    bus.pc_load    = (state == ST_JUMP) && jump_taken;
    bus.pc_in      = tgt_q;
    bus.ir         = ir_q;
    bus.exec_valid = exec_vld_q;
    halted         = (state == ST_HALT);
    fault          = (state == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ir_q       <= '0;
      tgt_q      <= '0;
      wait_cnt   <= '0;
      exec_vld_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      exec_vld_q <= (state_nxt == ST_EXEC) && (state != ST_EXEC);
      if (req_cyc && !bus.imem_ack) wait_cnt <= wait_cnt + 1'b1;
      else                          wait_cnt <= '0;
      if ((state == ST_FETCH) && accept)    ir_q  <= bus.imem_rdata;
      if ((state == ST_FETCH_OP) && accept) tgt_q <= ADDR_W'(bus.imem_rdata);
    end
  end

  // Structural invariants of the sequencer
  generate
    if (WAIT_MAX < 1) begin : g_bad_wait_max
      $error("WAIT_MAX must be at least 1");
    end
  endgenerate

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.pc_en && bus.pc_load));

  a_exec_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
    bus.exec_valid |-> (state == ST_EXEC));

  a_fault_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    fault |=> fault);

  a_halt_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> !(bus.imem_req || bus.pc_en || bus.pc_load));

  // IDLE is only reachable through reset, so the PC must still hold its reset value there.
  a_idle_pc: assert property (@(posedge clk) disable iff (!rst_n)
    (state == ST_IDLE) |-> (bus.pc_cur == RESET_VEC));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: zero/variable-wait memory, a program counter model and
// datapath stand-in around the DUT, driven by a per-cycle vector table plus corner sequences.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  logic run;
  logic halted;
  logic fault;
  logic ack_en;
  logic done_drv;
  logic zf_drv;

  logic [7:0] mem [256];
  logic [7:0] pc_q;

  int checks;
  int errors;

  fetch_sequencer_if #(.ADDR_W(8)) bus ();

  fetch_sequencer #(.ADDR_W(8), .RESET_VEC(8'h00), .WAIT_MAX(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .bus    (bus),
    .halted (halted),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks whenever enabled, even outside fetch states, so stray acks get exercised.
  assign bus.imem_ack   = ack_en;
  assign bus.imem_rdata = mem[bus.pc_cur];
  assign bus.pc_cur     = pc_q;
  assign bus.exec_done  = done_drv;
  assign bus.zero_flag  = zf_drv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           pc_q <= 8'h00;
    else if (bus.pc_load) pc_q <= bus.pc_in;
    else if (bus.pc_en)   pc_q <= pc_q + 8'h01;
  end

  logic [5:0] outs;
  assign outs = {bus.imem_req, bus.pc_en, bus.pc_load, bus.exec_valid, halted, fault};

  typedef struct {
    logic       run;
    logic       done;
    logic       zf;
    logic       ack;
    logic [5:0] exp_o;
    logic [7:0] exp_pc;
    logic [7:0] exp_ir;
    logic [7:0] exp_pcin;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic d, input logic z, input logic a,
                              input logic [5:0] o, input logic [7:0] pc,
                              input logic [7:0] irv, input logic [7:0] pin);
    vec_t v;
    v.run = r; v.done = d; v.zf = z; v.ack = a;
    v.exp_o = o; v.exp_pc = pc; v.exp_ir = irv; v.exp_pcin = pin;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nreq;
    checks = 0; errors = 0;
    run = 0; ack_en = 0; done_drv = 0; zf_drv = 0; rst_n = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'hA0; mem[8'h02] = 8'h40;
    mem[8'h40] = 8'hB0; mem[8'h41] = 8'h50;
    mem[8'h42] = 8'hB0; mem[8'h43] = 8'h60;
    mem[8'h60] = 8'hF0; mem[8'h61] = 8'h34; mem[8'h62] = 8'h56;

    // outs order: req, pc_en, pc_load, exec_valid, halted, fault
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h00, 8'h00, 8'h00)); // IDLE
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h00, 8'h00, 8'h00)); // FETCH 12
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h01, 8'h12, 8'h00)); // DECODE
    tbl.push_back(mk(1,1,0,1, 6'b000100, 8'h01, 8'h12, 8'h00)); // EXEC, done same cycle
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h01, 8'h12, 8'h00)); // FETCH A0
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h02, 8'hA0, 8'h00)); // DECODE
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h02, 8'hA0, 8'h00)); // FETCH_OP 40
    tbl.push_back(mk(1,0,0,1, 6'b001000, 8'h03, 8'hA0, 8'h40)); // JUMP taken
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h40, 8'hA0, 8'h40)); // FETCH B0
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h41, 8'hB0, 8'h40)); // DECODE
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h41, 8'hB0, 8'h40)); // FETCH_OP 50
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h42, 8'hB0, 8'h50)); // JZ not taken
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h42, 8'hB0, 8'h50)); // FETCH B0
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h43, 8'hB0, 8'h50)); // DECODE
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h43, 8'hB0, 8'h50)); // FETCH_OP 60
    tbl.push_back(mk(1,0,1,1, 6'b001000, 8'h44, 8'hB0, 8'h60)); // JZ taken
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h60, 8'hB0, 8'h60)); // FETCH F0
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h61, 8'hF0, 8'h60)); // DECODE
    tbl.push_back(mk(0,0,0,1, 6'b000010, 8'h61, 8'hF0, 8'h60)); // HALT
    tbl.push_back(mk(0,0,0,1, 6'b000010, 8'h61, 8'hF0, 8'h60)); // HALT
    tbl.push_back(mk(1,0,0,1, 6'b000010, 8'h61, 8'hF0, 8'h60)); // HALT, resume
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h61, 8'hF0, 8'h60)); // FETCH 34
    tbl.push_back(mk(1,1,0,1, 6'b000000, 8'h62, 8'h34, 8'h60)); // DECODE, stray done
    tbl.push_back(mk(1,0,0,1, 6'b000100, 8'h62, 8'h34, 8'h60)); // EXEC
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h62, 8'h34, 8'h60)); // EXEC wait
    tbl.push_back(mk(1,1,0,1, 6'b000000, 8'h62, 8'h34, 8'h60)); // EXEC done
    tbl.push_back(mk(1,0,0,0, 6'b100000, 8'h62, 8'h34, 8'h60)); // FETCH wait state
    tbl.push_back(mk(1,0,0,1, 6'b110000, 8'h62, 8'h34, 8'h60)); // FETCH 56
    tbl.push_back(mk(1,0,0,1, 6'b000000, 8'h63, 8'h56, 8'h60)); // DECODE

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outs", 32'(outs), 32'h0);
    check("reset ir", 32'(bus.ir), 32'h0);
    check("reset pc_in", 32'(bus.pc_in), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run = tbl[i].run; done_drv = tbl[i].done; zf_drv = tbl[i].zf; ack_en = tbl[i].ack;
      #2;
      check($sformatf("row%0d outs", i), 32'(outs), 32'(tbl[i].exp_o));
      check($sformatf("row%0d pc", i), 32'(bus.pc_cur), 32'(tbl[i].exp_pc));
      check($sformatf("row%0d ir", i), 32'(bus.ir), 32'(tbl[i].exp_ir));
      check($sformatf("row%0d pc_in", i), 32'(bus.pc_in), 32'(tbl[i].exp_pcin));
      @(negedge clk);
    end

    // Fetch timeout: no ack ever
    run = 1; ack_en = 0; done_drv = 0; zf_drv = 0;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 40 && !fault; i++) begin
      @(negedge clk);
      #2;
      if (bus.imem_req) nreq++;
    end
    check("timeout req cycles", 32'(nreq), 32'd15);
    check("timeout fault", 32'(fault), 32'd1);
    check("timeout req low", 32'(bus.imem_req), 32'd0);
    ack_en = 1;
    repeat (5) @(negedge clk);
    #2;
    check("fault sticky outs", 32'(outs), 32'b000001);

    // Ack arriving in the last allowed cycle is accepted
    ack_en = 0;
    do_reset();
    repeat (15) @(negedge clk);
    ack_en = 1;
    #2;
    check("late ack outs", 32'(outs), 32'b110000);
    @(negedge clk);
    ack_en = 0;
    #2;
    check("late ack decode outs", 32'(outs), 32'b000000);
    check("late ack ir", 32'(bus.ir), 32'h12);
    check("late ack pc", 32'(bus.pc_cur), 32'h01);

    // Reset during EXEC
    ack_en = 1; run = 1; done_drv = 0;
    do_reset();
    repeat (3) @(negedge clk);
    #2;
    check("pre-reset exec_valid", 32'(bus.exec_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset in exec outs", 32'(outs), 32'h0);
    check("reset in exec ir", 32'(bus.ir), 32'h0);
    run = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("idle after reset outs", 32'(outs), 32'h0);

    // Reset during FETCH with ack high
    run = 1;
    @(negedge clk);
    #2;
    check("pre-reset fetch outs", 32'(outs), 32'b110000);
    rst_n = 1'b0;
    #1;
    check("reset in fetch outs", 32'(outs), 32'h0);
    @(negedge clk);
    check("reset in fetch ir", 32'(bus.ir), 32'h0);
    check("reset in fetch pc", 32'(bus.pc_cur), 32'h0);
    run = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("idle hold outs", 32'(outs), 32'h0);
    run = 1;
    @(negedge clk);
    #2;
    check("restart fetch outs", 32'(outs), 32'b110000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
